// File: rtl/iteration_variable_counter_pkg.sv
// Shared definitions for the global-controller iteration-variable counter:
// default widths, FSM state encoding and flattened-vector slice indexing.
package gc_pkg;

  localparam int ITERATION_VARIABLE_WIDTH_DEF = 16;
  localparam int NUM_DIMENSIONS_DEF           = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } gc_state_e;

  // LSB position of dimension d inside a flattened {dim N-1, ..., dim 0} vector
  function automatic int slice_lsb(input int d, input int width);
    return d * width;
  endfunction

endpackage

// File: rtl/iteration_variable_counter_if.sv
// Handshake and bound/vector bundle between the controller and the iteration
// counter. ITERATION_STRIDE_EN adds the per-dimension stride input.
interface iteration_variable_counter_if #(
  parameter int ITERATION_VARIABLE_WIDTH = gc_pkg::ITERATION_VARIABLE_WIDTH_DEF,
  parameter int NUM_DIMENSIONS           = gc_pkg::NUM_DIMENSIONS_DEF
) ();

  localparam int VW = NUM_DIMENSIONS * ITERATION_VARIABLE_WIDTH;

  logic          start;
  logic          advance;
  logic [VW-1:0] ivar_lb;
  logic [VW-1:0] ivar_ub;
`ifdef ITERATION_STRIDE_EN
  logic [VW-1:0] ivar_step;
`endif
  logic [VW-1:0] ivar;
  logic          ivar_valid;
  logic          last;
  logic          busy;
  logic          done;

  modport master (
    output start, advance, ivar_lb, ivar_ub,
`ifdef ITERATION_STRIDE_EN
    output ivar_step,
`endif
    input  ivar, ivar_valid, last, busy, done
  );

  modport slave (
    input  start, advance, ivar_lb, ivar_ub,
`ifdef ITERATION_STRIDE_EN
    input  ivar_step,
`endif
    output ivar, ivar_valid, last, busy, done
  );

endinterface

// File: rtl/iteration_variable_counter_dim_counter.sv
// One loop dimension: holds its iteration value, steps on carry_in and wraps
// to lb once value+step would exceed ub (decided at width+1, never by overflow).
module iteration_dim_counter
  import gc_pkg::*;
#(
  parameter int W = ITERATION_VARIABLE_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         carry_in,
  input  logic [W-1:0] lb,
  input  logic [W-1:0] ub,
  input  logic [W-1:0] step,
  output logic [W-1:0] value,
  output logic         at_ub,
  output logic         carry_out
);

  logic signed [W:0] ub_ext_s;
  logic signed [W:0] sum_s;
  logic signed [W:0] next_sum_s;
  logic [W-1:0]      value_r;
  logic [W-1:0]      value_next_s;
  logic              wrap_s;

  // Next value and wrap; at_ub describes the value written at this edge
  always_comb begin
    ub_ext_s  = signed'({ub[W-1], ub});
    sum_s     = signed'({value_r[W-1], value_r}) + signed'({step[W-1], step});
    wrap_s    = (sum_s > ub_ext_s);
    carry_out = carry_in & wrap_s;
    if (load) begin
      value_next_s = lb;
    end else if (carry_in && wrap_s) begin
      value_next_s = lb;
    end else if (carry_in) begin
      value_next_s = sum_s[W-1:0];
    end else begin
      value_next_s = value_r;
    end
    next_sum_s = signed'({value_next_s[W-1], value_next_s}) + signed'({step[W-1], step});
    at_ub      = (next_sum_s > ub_ext_s);
  end

  // Iteration value register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= {W{1'b0}};
    end else begin
      value_r <= value_next_s;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/iteration_variable_counter.sv
// Steps a NUM_DIMENSIONS loop nest (dim 0 innermost) from lb to ub, one point
// per accepted advance. Optional ITERATION_STRIDE_EN adds per-dimension strides.
module iteration_variable_counter
  import gc_pkg::*;
#(
  parameter int ITERATION_VARIABLE_WIDTH = ITERATION_VARIABLE_WIDTH_DEF,
  parameter int NUM_DIMENSIONS           = NUM_DIMENSIONS_DEF
) (
  input logic                         clk,
  input logic                         rst_n,
  iteration_variable_counter_if.slave bus
);

  localparam int W  = ITERATION_VARIABLE_WIDTH;
  localparam int N  = NUM_DIMENSIONS;
  localparam int VW = N * W;

  gc_state_e     state_r;
  gc_state_e     state_next_s;
  logic [VW-1:0] lb_r;
  logic [VW-1:0] ub_r;
  logic [VW-1:0] step_r;
  logic [VW-1:0] step_in_s;
  logic [VW-1:0] lb_sel_s;
  logic [VW-1:0] ub_sel_s;
  logic [VW-1:0] step_sel_s;
  logic [VW-1:0] ivar_s;
  logic [N-1:0]  at_ub_s;
  logic          accept_start_s;
  logic          empty_s;
  logic          load_s;
  logic          step_en_s;
  logic          nest_wrap_s;
  logic          last_next_s;
  logic          valid_r;
  logic          last_r;
  logic          busy_r;
  logic          done_r;

`ifdef ITERATION_STRIDE_EN
  assign step_in_s = bus.ivar_step;
`else
  // Unit stride in every dimension
  always_comb begin
    step_in_s = {VW{1'b0}};
    for (int d = 0; d < N; d++) begin
      step_in_s[slice_lsb(d, W) +: W] = {{(W-1){1'b0}}, 1'b1};
    end
  end
`endif

  // Empty nest: some lb > ub, or a non-positive stride
  always_comb begin
    empty_s = 1'b0;
    for (int d = 0; d < N; d++) begin
      if ($signed(bus.ivar_lb[slice_lsb(d, W) +: W]) > $signed(bus.ivar_ub[slice_lsb(d, W) +: W])) begin
        empty_s = 1'b1;
      end else if ($signed(step_in_s[slice_lsb(d, W) +: W]) < $signed({{(W-1){1'b0}}, 1'b1})) begin
        empty_s = 1'b1;
      end else begin
        empty_s = empty_s;
      end
    end
  end

  assign accept_start_s = (state_r == IDLE) && bus.start;
  assign step_en_s      = (state_r == RUN) && bus.advance;

  // Bounds follow the live inputs only while idle; on the final accept the
  // whole nest would wrap, so the current point is reloaded and ivar holds.
  always_comb begin
    if (state_r == IDLE) begin
      lb_sel_s   = bus.ivar_lb;
      ub_sel_s   = bus.ivar_ub;
      step_sel_s = step_in_s;
    end else if (nest_wrap_s) begin
      lb_sel_s   = ivar_s;
      ub_sel_s   = ub_r;
      step_sel_s = step_r;
    end else begin
      lb_sel_s   = lb_r;
      ub_sel_s   = ub_r;
      step_sel_s = step_r;
    end
  end

  // Bound capture at an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_r   <= {VW{1'b0}};
      ub_r   <= {VW{1'b0}};
      step_r <= {VW{1'b0}};
    end else if (accept_start_s) begin
      lb_r   <= bus.ivar_lb;
      ub_r   <= bus.ivar_ub;
      step_r <= step_in_s;
    end
  end

  for (genvar d = 0; d < N; d++) begin : g_dim
    logic cin_s;
    logic cout_s;
    if (d == 0) begin : g_first
      assign cin_s = step_en_s;
    end else begin : g_rest
      assign cin_s = g_dim[d-1].cout_s;
    end
    iteration_dim_counter #(.W(W)) u_dim (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s),
      .carry_in  (cin_s),
      .lb        (lb_sel_s[slice_lsb(d, W) +: W]),
      .ub        (ub_sel_s[slice_lsb(d, W) +: W]),
      .step      (step_sel_s[slice_lsb(d, W) +: W]),
      .value     (ivar_s[slice_lsb(d, W) +: W]),
      .at_ub     (at_ub_s[d]),
      .carry_out (cout_s)
    );
  end

  assign nest_wrap_s = g_dim[N-1].cout_s;

  // Next-state and load decode
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && empty_s) begin
          state_next_s = FINISH;
        end else if (bus.start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (nest_wrap_s) begin
          state_next_s = FINISH;
          load_s       = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign last_next_s = (state_next_s == RUN) && (&at_ub_s);

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s == RUN);
      last_r  <= last_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == FINISH);
    end
  end

  assign bus.ivar       = ivar_s;
  assign bus.ivar_valid = valid_r;
  assign bus.last       = last_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule
